s38584_qual_capture_bank: RTL and testbench
===========================================

// Module: s38584_qual_capture_bank
// PURPOSE
//  Parametrised, sequenced successor to the single-bit qualified next-state mux in the s38584 partition.
//  Holds NCH capture bits. Each bit is loaded from one of NSRC sources (chosen by an encoded select) or
//  from an alternate value (chosen by a qualifier-pattern match).
//  A start-triggered sequencer updates one channel per enabled cycle and reports busy/done.
//  Sits between the s38584 status decode (qualifier vector) and the downstream capture flops.
// PARAMETERS
//  NCH   4       number of capture channels (>=1)
//  NSRC  8       sources per channel (>=2)
//  SELW  3       select width per channel; must equal clog2(NSRC)
//  QW    8       qualifier vector width
//  QPAT  8'hE5   qualifier pattern required to arm (QW bits)
// PORTS
//  CK     in   1          clock, rising edge
//  RST    in   1          synchronous active-high reset
//  en     in   1          global update enable; 0 = every register holds (stall)
//  start  in   1          one-cycle pulse, begins a scan of all channels
//  qual   in   QW         qualifier vector, sampled in LOAD
//  alt    in   NCH        alternate value per channel (used when not armed)
//  src    in   NCH*NSRC   source bits, channel c at [c*NSRC +: NSRC]
//  sel    in   NCH*SELW   encoded source select, channel c at [c*SELW +: SELW]
//  q      out  NCH        capture register bits
//  busy   out  1          high in LOAD and SCAN
//  done   out  1          one-cycle pulse when scan completes
//  err    out  1          sticky: an out-of-range select was seen in this scan
//  hits   out  clog2(NCH+1)  number of channels loaded from src in the last scan
// BEHAVIOUR
//  Reset (RST=1 at a rising edge; overrides every other input):
//   q=0, busy=0, done=0, err=0, hits=0, state=IDLE, ch=0, arm_r=0.
//  FSM states: IDLE, LOAD, SCAN, DONE.
//   IDLE -> LOAD when start=1 and en=1. start is ignored in every other state, and when en=0.
//   LOAD: arm_r <= (qual == QPAT); err <= 0; hits <= 0; ch <= 0. -> SCAN (needs en=1, else hold in LOAD).
//   SCAN, on each cycle with en=1, update channel ch:
//    - arm_r=1 and sel[ch] < NSRC: q[ch] <= src[ch*NSRC + sel[ch]]; hits <= hits+1
//    - arm_r=1 and sel[ch] >= NSRC: q[ch] holds; err <= 1
//    - arm_r=0: q[ch] <= alt[ch]; sel is not checked
//    - ch==NCH-1 -> DONE; otherwise ch <= ch+1
//   SCAN with en=0: no state, ch, q, err or hits change (stall of any length).
//   DONE: done=1 for exactly one cycle, regardless of en -> IDLE.
//  Other rules:
//   - Scan latency with en held 1: start at edge k gives LOAD at k+1, SCAN k+2..k+NCH+1, done high during cycle k+NCH+2.
//   - busy = (state==LOAD || state==SCAN), decoded from registered state.
//   - Non-current channels are never written. q changes only in SCAN.
//   - src, sel and alt are sampled live in each channel's own update cycle. qual is sampled only in LOAD.
//   - hits saturates at NCH and cannot wrap. ch never exceeds NCH-1.
//   - err and hits keep their values through IDLE until the next LOAD.
//   - RST during LOAD or SCAN aborts the scan immediately: q is cleared and no done pulse follows.
// TESTING
//  T1 reset: RST=1 for 2 cycles, then 0 -> q=0, busy=0, done=0, err=0, hits=0.
//  T2 armed scan: qual=8'hE5, sel={3,0,7,2}, src ch-bits set only at those indices, en=1, start pulse
//     -> q=4'b1111, hits=4, err=0, done 6 cycles after start edge.
//  T3 unarmed: qual=8'hE4, alt=4'b1010 -> q=4'b1010, hits=0, regardless of src/sel.
//  T4 stall: en dropped for 3 cycles during SCAN at ch=1 -> q/ch frozen; done delayed by exactly 3 cycles.
//  T5 out-of-range: NSRC=6, sel ch2=7, armed -> q[2] holds prior value, err=1, hits=3;
//     start during busy is ignored (no restart).
//  T6 reset mid-scan: RST at SCAN ch=2 -> q=0, busy=0 next cycle, no done pulse.

Source files
------------

// File: rtl/s38584_qual_capture_bank_if.sv
// Bus bundle for the s38584 qualified capture bank.
// The master side drives the enable, start, qualifier and per-channel data.
// The slave side (the capture bank) returns the capture bits and the scan status.
interface s38584_qual_capture_bank_if #(
    parameter int NCH  = 4,
    parameter int NSRC = 8,
    parameter int SELW = 3,
    parameter int QW   = 8
);
    logic                       en;
    logic                       start;
    logic [QW-1:0]              qual;
    logic [NCH-1:0]             alt;
    logic [NCH*NSRC-1:0]        src;
    logic [NCH*SELW-1:0]        sel;
    logic [NCH-1:0]             q;
    logic                       busy;
    logic                       done;
    logic                       err;
    logic [$clog2(NCH+1)-1:0]   hits;

    modport master (
        output en, start, qual, alt, src, sel,
        input  q, busy, done, err, hits
    );

    modport slave (
        input  en, start, qual, alt, src, sel,
        output q, busy, done, err, hits
    );
endinterface

// File: rtl/s38584_qual_capture_bank.sv
// Qualified capture bank: NCH capture bits, each loaded either from one of
// NSRC sources (encoded select) when the qualifier matches QPAT, or from an
// alternate bit otherwise. A start-triggered sequencer visits one channel per
// enabled cycle and reports busy/done, a sticky select-range error and the
// number of channels that were loaded from a source.
module s38584_qual_capture_bank #(
    parameter int              NCH  = 4,
    parameter int              NSRC = 8,
    parameter int              SELW = 3,
    parameter int              QW   = 8,
    parameter logic [QW-1:0]   QPAT = 8'hE5
) (
    input  logic                        CK,
    input  logic                        RST,
    s38584_qual_capture_bank_if.slave   bus
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int HW  = $clog2(NCH + 1);
    localparam logic [CHW-1:0]  LAST_CH  = CHW'(NCH - 1);
    localparam logic [HW-1:0]   HITS_MAX = HW'(NCH);
    // One extra bit so NSRC itself is representable when NSRC == 2**SELW.
    localparam logic [SELW:0]   NSRC_LIM = (SELW + 1)'(NSRC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [CHW-1:0]     r_ch;
    logic               r_arm;
    logic [NCH-1:0]     r_q;
    logic               r_done;
    logic               r_err;
    logic [HW-1:0]      r_hits;

    logic [SELW-1:0]    w_sel;
    logic               w_alt_bit;
    logic               w_sel_ok;
    logic               w_src_bit;
    int                 w_src_idx;

    // Pick the select field and alternate bit of the channel being scanned.
    always_comb begin
        w_sel     = {SELW{1'b0}};
        w_alt_bit = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            w_sel     = (r_ch == CHW'(c)) ? bus.sel[c*SELW +: SELW] : w_sel;
            w_alt_bit = (r_ch == CHW'(c)) ? bus.alt[c] : w_alt_bit;
        end
    end

    // Range-check the select and fetch the addressed source bit of the current channel.
    always_comb begin
        w_sel_ok  = ({1'b0, w_sel} < NSRC_LIM);
        w_src_idx = int'(r_ch) * NSRC + int'(w_sel);
        w_src_bit = 1'b0;
        // Constant-index scan keeps an out-of-range select from reading past src.
        for (int i = 0; i < NCH*NSRC; i++) begin
            w_src_bit = (w_sel_ok && (i == w_src_idx)) ? bus.src[i] : w_src_bit;
        end
    end

    // Sequencer and capture registers; en=0 freezes everything except the DONE exit.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_ch    <= {CHW{1'b0}};
            r_arm   <= 1'b0;
            r_q     <= {NCH{1'b0}};
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_hits  <= {HW{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.en && bus.start) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.en) begin
                        r_arm   <= (bus.qual == QPAT);
                        r_err   <= 1'b0;
                        r_hits  <= {HW{1'b0}};
                        r_ch    <= {CHW{1'b0}};
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (bus.en) begin
                        if (r_arm) begin
                            if (w_sel_ok) begin
                                r_q[r_ch] <= w_src_bit;
                                if (r_hits < HITS_MAX) begin
                                    r_hits <= r_hits + HW'(1);
                                end
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_q[r_ch] <= w_alt_bit;
                        end
                        if (r_ch == LAST_CH) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_ch <= r_ch + CHW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.q    = r_q;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.hits = r_hits;
    assign bus.busy = (r_state == S_LOAD) || (r_state == S_SCAN);

endmodule

// File: tb/tb_s38584_qual_capture_bank.sv
// Directed bench for the qualified capture bank. Instance A uses the default
// 8-source configuration, instance B uses 6 sources so a 3-bit select can go
// out of range. Both share clock, reset, enable, start, qualifier and alt.
module tb_s38584_qual_capture_bank;

    logic        CK;
    logic        RST;
    logic        en;
    logic        start;
    logic [7:0]  qual;
    logic [3:0]  alt;
    logic [31:0] src_a;
    logic [11:0] sel_a;
    logic [23:0] src_b;
    logic [11:0] sel_b;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    logic saw_done;

    s38584_qual_capture_bank_if                bus_a ();
    s38584_qual_capture_bank_if #(.NSRC(6))    bus_b ();

    assign bus_a.en    = en;
    assign bus_a.start = start;
    assign bus_a.qual  = qual;
    assign bus_a.alt   = alt;
    assign bus_a.src   = src_a;
    assign bus_a.sel   = sel_a;
    assign bus_b.en    = en;
    assign bus_b.start = start;
    assign bus_b.qual  = qual;
    assign bus_b.alt   = alt;
    assign bus_b.src   = src_b;
    assign bus_b.sel   = sel_b;

    s38584_qual_capture_bank u_dut_a (
        .CK  (CK),
        .RST (RST),
        .bus (bus_a)
    );

    s38584_qual_capture_bank #(.NSRC(6)) u_dut_b (
        .CK  (CK),
        .RST (RST),
        .bus (bus_b)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Pulse start, optionally re-pulse start or stall en mid-scan, and
    // return the number of edges from the start edge until done is seen.
    task automatic run_scan(input int restart_at, input int stall_at, input int stall_len,
                            input logic [3:0] stall_q, input logic [2:0] stall_hits,
                            output int lat_o);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat_o = 1;
        while (bus_a.done !== 1'b1 && lat_o < 40) begin
            start = (lat_o == restart_at);
            if (stall_len > 0 && lat_o == stall_at) en = 1'b0;
            if (stall_len > 0 && lat_o == stall_at + stall_len) begin
                chk_eq("stall_q",    32'(bus_a.q),    32'(stall_q));
                chk_eq("stall_hits", 32'(bus_a.hits), 32'(stall_hits));
                chk_eq("stall_busy", 32'(bus_a.busy), 32'(1'b1));
                en = 1'b1;
            end
            tick();
            lat_o++;
        end
        start = 1'b0;
        en    = 1'b1;
        chk_eq("done_seen", 32'(bus_a.done), 32'(1'b1));
        tick();
        chk_eq("done_one_cycle", 32'(bus_a.done), 32'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST   = 1'b1;
        en    = 1'b0;
        start = 1'b0;
        qual  = 8'h00;
        alt   = 4'b0000;
        src_a = 32'h0000_0000;
        sel_a = 12'h000;
        src_b = 24'h00_0000;
        sel_b = 12'h000;

        // T1 reset
        tick();
        tick();
        RST = 1'b0;
        chk_eq("rst_q",    32'(bus_a.q),    32'(4'b0000));
        chk_eq("rst_busy", 32'(bus_a.busy), 32'(1'b0));
        chk_eq("rst_done", 32'(bus_a.done), 32'(1'b0));
        chk_eq("rst_err",  32'(bus_a.err),  32'(1'b0));
        chk_eq("rst_hits", 32'(bus_a.hits), 32'(3'd0));
        chk_eq("rst_q_b",  32'(bus_b.q),    32'(4'b0000));

        // T2 armed scan: ch3 sel 3, ch2 sel 0, ch1 sel 7, ch0 sel 2
        en    = 1'b1;
        qual  = 8'hE5;
        sel_a = {3'd3, 3'd0, 3'd7, 3'd2};
        src_a = 32'h0801_8004;
        tick();
        chk_eq("idle_busy", 32'(bus_a.busy), 32'(1'b0));
        run_scan(0, 0, 0, 4'b0000, 3'd0, lat);
        chk_eq("t2_latency", 32'(lat),          32'd6);
        chk_eq("t2_q",       32'(bus_a.q),      32'(4'b1111));
        chk_eq("t2_hits",    32'(bus_a.hits),   32'(3'd4));
        chk_eq("t2_err",     32'(bus_a.err),    32'(1'b0));
        chk_eq("t2_busy",    32'(bus_a.busy),   32'(1'b0));

        // T3 unarmed: alt wins regardless of src/sel
        qual  = 8'hE4;
        alt   = 4'b1010;
        src_a = 32'hFFFF_FFFF;
        run_scan(0, 0, 0, 4'b0000, 3'd0, lat);
        chk_eq("t3_latency", 32'(lat),        32'd6);
        chk_eq("t3_q",       32'(bus_a.q),    32'(4'b1010));
        chk_eq("t3_hits",    32'(bus_a.hits), 32'(3'd0));
        chk_eq("t3_err",     32'(bus_a.err),  32'(1'b0));

        // T4 stall 3 cycles at ch=1 (ch0 already loaded: 1010 -> 1011)
        qual  = 8'hE5;
        src_a = 32'h0001_0004;
        run_scan(0, 3, 3, 4'b1011, 3'd1, lat);
        chk_eq("t4_latency", 32'(lat),        32'd9);
        chk_eq("t4_q",       32'(bus_a.q),    32'(4'b0101));
        chk_eq("t4_hits",    32'(bus_a.hits), 32'(3'd4));
        chk_eq("t4_q_b",     32'(bus_b.q),    32'(4'b0000));

        // Give instance B a known prior value with q[2]=1
        qual = 8'hE4;
        alt  = 4'b0100;
        run_scan(0, 0, 0, 4'b0000, 3'd0, lat);
        chk_eq("prep_q_b", 32'(bus_b.q), 32'(4'b0100));

        // T5 out-of-range on B: ch3 sel 0, ch2 sel 7, ch1 sel 5, ch0 sel 1; start re-pulsed while busy
        qual  = 8'hE5;
        sel_b = {3'd0, 3'd7, 3'd5, 3'd1};
        src_b = 24'h04_0802;
        run_scan(3, 0, 0, 4'b0000, 3'd0, lat);
        chk_eq("t5_latency", 32'(lat),        32'd6);
        chk_eq("t5_q_b",     32'(bus_b.q),    32'(4'b1111));
        chk_eq("t5_err_b",   32'(bus_b.err),  32'(1'b1));
        chk_eq("t5_hits_b",  32'(bus_b.hits), 32'(3'd3));
        chk_eq("t5_err_a",   32'(bus_a.err),  32'(1'b0));
        tick();
        tick();
        chk_eq("t5_no_restart", 32'(bus_b.busy), 32'(1'b0));
        chk_eq("t5_err_sticky", 32'(bus_b.err),  32'(1'b1));
        chk_eq("t5_hits_kept",  32'(bus_b.hits), 32'(3'd3));

        // T6 reset while scanning ch=2
        src_a = 32'h0801_8004;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk_eq("t6_pre_q",    32'(bus_a.q),    32'(4'b0111));
        chk_eq("t6_pre_busy", 32'(bus_a.busy), 32'(1'b1));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_eq("t6_q",    32'(bus_a.q),    32'(4'b0000));
        chk_eq("t6_busy", 32'(bus_a.busy), 32'(1'b0));
        chk_eq("t6_hits", 32'(bus_a.hits), 32'(3'd0));
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_a.done === 1'b1) saw_done = 1'b1;
        end
        chk_eq("t6_no_done", 32'(saw_done),   32'(1'b0));
        chk_eq("t6_idle",    32'(bus_a.busy), 32'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
